ahb_apb_reset_seq: RTL and testbench

AHB_APB_RESET_SEQ -- requirements
Module: ahb_apb_reset_seq

---
 rtl/ahb_apb_reset_seq.sv | 114 +++++++++++
 tb/tb_ahb_apb_reset_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ahb_apb_reset_seq.sv
// Reset sequencer for an AHB-APB bridge: stretches reset, releases APB before AHB,
// and drains in-flight transfers before applying a software reset.
//   state   | meaning
//   ASSERT  | both resets low, stretch count running
//   REL_APB | APB released, AHB still held
//   RUN     | both resets released, rst_done high
//   DRAIN   | hold new AHB transfers, wait for bridge idle or timeout
module ahb_apb_reset_seq #(
  parameter int STRETCH_CYCLES = 8,
  parameter int APB_DELAY      = 4,
  parameter int DRAIN_MAX      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_rst_req,
  input  logic       bridge_busy,
  output logic       hresetn_o,
  output logic       presetn_o,
  output logic       hold_o,
  output logic       rst_done,
  output logic [1:0] rst_cause
);

  localparam logic [7:0] STRETCH_LAST = 8'(STRETCH_CYCLES - 1);
  localparam logic [7:0] APB_LAST     = 8'(APB_DELAY - 1);
  localparam logic [7:0] DRAIN_LAST   = 8'(DRAIN_MAX - 1);

  localparam logic [1:0] CAUSE_EXT      = 2'b01;
  localparam logic [1:0] CAUSE_SW       = 2'b10;
  localparam logic [1:0] CAUSE_SW_FORCE = 2'b11;

  typedef enum logic [1:0] {ASSERT, REL_APB, RUN, DRAIN} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] cause_nxt;
  logic       hresetn_nxt, presetn_nxt, hold_nxt, done_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 8'd1;
    cause_nxt = rst_cause;
    case (state)
      ASSERT: begin
        if (cnt == STRETCH_LAST) state_nxt = REL_APB;
      end
      REL_APB: begin
        if (cnt == APB_LAST) state_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = cnt;
        if (sw_rst_req) begin
          state_nxt = DRAIN;
          cause_nxt = CAUSE_SW;
        end
      end
      DRAIN: begin
        // idle takes priority over the timeout on the same edge
        if (!bridge_busy) begin
          state_nxt = ASSERT;
        end else if (cnt == DRAIN_LAST) begin
          state_nxt = ASSERT;
          cause_nxt = CAUSE_SW_FORCE;
        end
      end
      default: state_nxt = ASSERT;
    endcase
    if (state_nxt != state) cnt_nxt = 8'd0;
  end

  // outputs are decoded from the next state so they change with the state register
  always_comb begin
    hresetn_nxt = 1'b0;
    presetn_nxt = 1'b0;
    hold_nxt    = 1'b0;
    done_nxt    = 1'b0;
    case (state_nxt)
      ASSERT: ;
      REL_APB: presetn_nxt = 1'b1;
      RUN: begin
        hresetn_nxt = 1'b1;
        presetn_nxt = 1'b1;
        done_nxt    = 1'b1;
      end
      DRAIN: begin
        hresetn_nxt = 1'b1;
        presetn_nxt = 1'b1;
        hold_nxt    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ASSERT;
      cnt       <= 8'd0;
      hresetn_o <= 1'b0;
      presetn_o <= 1'b0;
      hold_o    <= 1'b0;
      rst_done  <= 1'b0;
      rst_cause <= CAUSE_EXT;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hresetn_o <= hresetn_nxt;
      presetn_o <= presetn_nxt;
      hold_o    <= hold_nxt;
      rst_done  <= done_nxt;
      rst_cause <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_apb_reset_seq.sv
// Randomized bench for ahb_apb_reset_seq, checked every cycle against a
// timeline model (edges since sequence start, drain edges spent).
module tb_ahb_apb_reset_seq;

  localparam int S = 8;
  localparam int A = 4;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic       bridge_busy = 1'b0;
  logic       hresetn_o, presetn_o, hold_o, rst_done;
  logic [1:0] rst_cause;

  ahb_apb_reset_seq #(.STRETCH_CYCLES(S), .APB_DELAY(A), .DRAIN_MAX(D)) dut (
    .clk(clk), .reset(reset), .sw_rst_req(sw_rst_req), .bridge_busy(bridge_busy),
    .hresetn_o(hresetn_o), .presetn_o(presetn_o), .hold_o(hold_o),
    .rst_done(rst_done), .rst_cause(rst_cause)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: in_seq -> t edges elapsed since sequence start; draining -> d busy edges
  bit in_seq   = 1'b1;
  bit draining = 1'b0;
  int t = 0;
  int d = 0;
  int cause = 1;
  int forced_seen = 0;
  int boundary_seen = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit sw, input bit busy);
    if (r) begin
      in_seq = 1; draining = 0; t = 0; cause = 1;
    end else if (in_seq) begin
      t++;
      if (t == S + A) in_seq = 0;
    end else if (draining) begin
      if (!busy) begin
        if (d == D - 1) boundary_seen++;
        draining = 0; in_seq = 1; t = 0;
      end else begin
        d++;
        if (d == D) begin
          cause = 3; forced_seen++;
          draining = 0; in_seq = 1; t = 0;
        end
      end
    end else if (sw) begin
      draining = 1; d = 0; cause = 2;
    end
  endtask

  task automatic step(input bit r, input bit sw, input bit busy);
    bit ep, eh, ehold, edone;
    reset = r; sw_rst_req = sw; bridge_busy = busy;
    @(posedge clk);
    model_edge(r, sw, busy);
    @(negedge clk);
    if (in_seq) begin
      ep = (t >= S); eh = 0; ehold = 0; edone = 0;
    end else if (draining) begin
      ep = 1; eh = 1; ehold = 1; edone = 0;
    end else begin
      ep = 1; eh = 1; ehold = 0; edone = 1;
    end
    chk("presetn", 8'(presetn_o), 8'(ep));
    chk("hresetn", 8'(hresetn_o), 8'(eh));
    chk("hold", 8'(hold_o), 8'(ehold));
    chk("rst_done", 8'(rst_done), 8'(edone));
    chk("rst_cause", 8'(rst_cause), 8'(cause));
    chk("order", 8'(hresetn_o & ~presetn_o), 8'd0);
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while ((in_seq || draining) && n < budget) begin
      step(0, 0, 0);
      n++;
    end
    chk("reach_run", 8'(in_seq || draining), 8'd0);
  endtask

  int busy_mode;

  initial begin
    @(negedge clk);
    repeat (3) step(1, 0, 0);
    wait_run(40);
    // sw reset with bridge idle
    step(0, 1, 0);
    wait_run(40);
    // forced drain timeout
    step(0, 1, 1);
    repeat (D) step(0, 0, 1);
    wait_run(40);
    // busy drops exactly on the last drain edge
    step(0, 1, 1);
    repeat (D - 1) step(0, 0, 1);
    step(0, 0, 0);
    wait_run(40);
    // reset during REL_APB, and sw pulses ignored in ASSERT/REL_APB/DRAIN
    step(1, 0, 0);
    repeat (S + 1) step(0, 1, 0);
    step(1, 0, 0);
    repeat (3) step(0, 1, 1);
    wait_run(40);
    step(0, 1, 1);
    repeat (4) step(0, 1, 1);
    step(1, 0, 1);
    wait_run(40);

    busy_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r, sw, busy;
      if (i % 37 == 0) busy_mode = $urandom_range(0, 2);
      r  = ($urandom_range(0, 99) == 0);
      sw = ($urandom_range(0, 9) == 0);
      case (busy_mode)
        0: busy = $urandom_range(0, 1);
        1: busy = ($urandom_range(0, 15) != 0);
        default: busy = ($urandom_range(0, 7) == 0);
      endcase
      step(r, sw, busy);
    end
    chk("forced_hit", 8'(forced_seen > 0), 8'd1);
    chk("boundary_hit", 8'(boundary_seen > 0), 8'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
